rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters. It produces a registered one-hot grant, the grant's 3-bit binary index (the same code as the 8-to-3 encoder), and a valid flag. The grant is held while the owner keeps requesting, up to a programmable hold limit, after which it is forcibly rotated. It sits in front of the shared datapath, so downstream logic steers by `o_gnt_idx` only.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant while others are waiting. Legal range 1..255; 0 means unlimited.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_req` input 8: request vector; bit k is requester k; level-sensitive.
- `o_gnt` output 8: one-hot grant, or all zeros when idle. Registered.
- `o_gnt_idx` output 3: binary index of the granted bit; holds the last value when idle. Registered.
- `o_gnt_vld` output 1: high while any grant is active; equals OR of `o_gnt`.
- `o_timeout` output 1: one-cycle pulse when a grant is forcibly rotated by `MAX_HOLD`.

## Operation
- **State:** owner index `own` (3b), `busy` flag, round-robin pointer `ptr` (3b, the next search start), hold counter `hcnt` (8b).
- **Search function:** the first set bit of the masked request vector, scanning `ptr`, `ptr+1`, …, `ptr+7` modulo 8.
  - Index wrap 7→0 is mandatory.
- **IDLE (`busy`=0):**
  - If `i_req`≠0, grant the search winner W: `busy`←1, `own`←W, `ptr`←W+1 (mod 8), `hcnt`←0.
  - Otherwise stay idle.
- **GRANT (`busy`=1):**
  - **Release:** `i_req[own]`=0 at an edge. Search `i_req`, with `own` naturally excluded. If there is a winner, grant it on the same edge (no dead cycle). If not, go to IDLE: `o_gnt`←0, `o_gnt_vld`←0.
  - **Hold:** `i_req[own]`=1 and `hcnt`<`MAX_HOLD`-1, or `MAX_HOLD`=0. `hcnt` increments, saturating at 255; the grant is unchanged.
  - **Timeout:** `i_req[own]`=1, `MAX_HOLD`≠0, and `hcnt`=`MAX_HOLD`-1.
    - If any other request is pending, search with bit `own` masked, grant that winner, pulse `o_timeout` for 1 cycle, and set `hcnt`←0.
    - If no other request is pending, the owner keeps the grant, `hcnt`←0, and no `o_timeout` pulse is issued.
- **Outputs:** `o_gnt` = 1<<`own` when `busy`, else 0. `o_gnt_idx` = `own`.
- **Fairness:** requests arriving while a grant is active never preempt it, except through the timeout rule. Under continuous full requests, grants cycle 0,1,…,7,0.
- **Reset values:**
  - `o_gnt`=8'h00, `o_gnt_idx`=3'd0, `o_gnt_vld`=0, `o_timeout`=0.
  - `ptr`=0, `hcnt`=0, state IDLE.
  - Reset asserted mid-grant drops the grant immediately (asynchronously), without waiting for a clock edge.
- **Requester rule:** a requester deasserts `i_req` only after it has finished using the resource. The arbiter does not check this.

## Timing
- **Grant latency:** a request sampled at edge N produces a grant visible after edge N. Requests asserted before edge N therefore see the grant in cycle N+1.
- **Release:** the owner drops `i_req` before edge N. After edge N, either the new owner is visible or the arbiter is idle. The handover gap is 0 cycles.
- **Max hold:** an owner sees at most `MAX_HOLD` consecutive cycles of `o_gnt` while competitors wait. The `o_timeout` pulse coincides with the first cycle of the new grant.
- **Simultaneous release and new requests:** the search uses the `i_req` value sampled at the same edge.
- **Idle detection:** `o_gnt_vld` falls in the cycle after the last request drops.
- **Reset release:** `rst_n` deasserts asynchronously. The first grant can occur on the first rising edge after deassertion.
- **Critical path:** the 8-way rotate/priority search plus encode, which must complete in one cycle.

## Test plan
- **Reset:** hold `rst_n`=0 with `i_req`=8'hFF.
  - Expect `o_gnt`=0, `o_gnt_vld`=0, `o_gnt_idx`=0.
  - Release reset: after the first edge, `o_gnt`=8'h01 and `o_gnt_idx`=0.
- **Rotation:** `i_req`=8'hFF, and each owner drops its bit for one cycle after being granted.
  - Expect grant order 0,1,2,…,7,0 with no idle cycle between grants.
- **Wrap and skip:** grant owned by 6, `i_req`=8'b0000_0101, then 6 drops.
  - Next grant is idx 0, then idx 2. Idx 7 is never granted.
- **Timeout:** `MAX_HOLD`=4, requester 3 held high, requester 5 asserted.
  - 3 holds for exactly 4 cycles, then the grant moves to 5 with `o_timeout`=1 for 1 cycle.
  - With 5 absent, 3 keeps the grant and `o_timeout` stays 0.
- **Idle and mid-operation reset:**
  - Single requester 4 drops its request: `o_gnt_vld`=0 on the next cycle.
  - Asserting `rst_n`=0 mid-grant clears `o_gnt` before the next clock edge, and `ptr` returns to 0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a registered one-hot grant,
// its binary index, a valid flag and a bounded hold time. A grant is kept while
// its owner keeps requesting, and is forcibly rotated after MAX_HOLD cycles if
// somebody else is waiting (MAX_HOLD = 0 disables the limit).
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_req,
  output logic [7:0] o_gnt,
  output logic [2:0] o_gnt_idx,
  output logic       o_gnt_vld,
  output logic       o_timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [2:0] own_q,   own_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [7:0] hcnt_q,  hcnt_d;
  logic       tmo_q,   tmo_d;

  logic [7:0] own_onehot;
  logic [7:0] search_req;
  logic       win_vld;
  logic [2:0] win_idx;

  // First set bit of req scanning start, start+1, ... modulo 8.
  // Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic        found;
    logic [2:0]  idx;
    dbl   = {req, req} >> start;
    rot   = dbl[7:0];
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = start + 3'(i);
      end
    end
    return {found, idx};
  endfunction

  // Search winner; while granting, the owner's own bit is excluded so one
  // search serves both release (bit already low) and forced rotation.
  always_comb begin
    own_onehot = 8'b1 << own_q;
    search_req = i_req & ((state_q == ST_GRANT) ? ~own_onehot : '1);
    {win_vld, win_idx} = rr_pick(search_req, ptr_q);
  end

  // Next-state: idle grant, release/handover, hold counting and timeout rotation.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          own_d   = win_idx;
          ptr_d   = win_idx + 3'd1;
          hcnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!i_req[own_q]) begin
          if (win_vld) begin
            own_d  = win_idx;
            ptr_d  = win_idx + 3'd1;
            hcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (HOLD_EN && (hcnt_q == HOLD_LAST)) begin
          hcnt_d = '0;
          if (win_vld) begin
            own_d = win_idx;
            ptr_d = win_idx + 3'd1;
            tmo_d = 1'b1;
          end
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any grant without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    o_gnt     = (state_q == ST_GRANT) ? own_onehot : '0;
    o_gnt_idx = own_q;
    o_gnt_vld = (state_q == ST_GRANT);
    o_timeout = tmo_q;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8 (MAX_HOLD = 4): directed vector table, hand-written
// reset sequences and randomized traffic against a behavioural model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_req;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_idx;
  logic       o_gnt_vld;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx),
    .o_gnt_vld (o_gnt_vld),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "held" counts the cycles the current owner has seen
  // its grant, starting at 1 on the cycle the grant first appears.
  int m_busy, m_own, m_ptr, m_held, m_to;

  function automatic int find_first(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_give(input int w);
    m_busy = 1; m_own = w; m_ptr = (w + 1) % 8; m_held = 1;
  endtask

  task automatic model_edge(input logic [7:0] r);
    int w;
    logic [7:0] others;
    m_to = 0;
    if (m_busy == 0) begin
      w = find_first(r, m_ptr);
      if (w >= 0) model_give(w);
    end else if (!r[m_own]) begin
      w = find_first(r, m_ptr);
      if (w >= 0) model_give(w);
      else m_busy = 0;
    end else if (MH != 0 && m_held >= MH) begin
      others = r;
      others[m_own] = 1'b0;
      if (others != 0) begin
        model_give(find_first(others, m_ptr));
        m_to = 1;
      end else begin
        m_held = 1;
      end
    end else begin
      m_held++;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_gnt"}, o_gnt, (m_busy != 0) ? 8'(1 << m_own) : 8'h00);
    chk({tag, "_idx"}, {5'd0, o_gnt_idx}, 8'(m_own));
    chk({tag, "_vld"}, {7'd0, o_gnt_vld}, 8'(m_busy));
    chk({tag, "_to"},  {7'd0, o_timeout}, 8'(m_to));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic [7:0] r);
    i_req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] req, input logic [7:0] gnt,
                              input logic [2:0] idx, input logic vld, input logic to);
    vec_t v;
    v.req = req; v.gnt = gnt; v.idx = idx; v.vld = vld; v.to = to;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    // Rotation: each owner drops its bit for one cycle after being granted.
    add(8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'hFE, 8'h02, 3'd1, 1'b1, 1'b0);
    add(8'hFD, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'hFB, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'hF7, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'hEF, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'hDF, 8'h40, 3'd6, 1'b1, 1'b0);
    add(8'hBF, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h7F, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // Wrap and skip: owner 6 releases with 0 and 2 pending, 7 absent.
    add(8'h40, 8'h40, 3'd6, 1'b1, 1'b0);
    add(8'h45, 8'h40, 3'd6, 1'b1, 1'b0);
    add(8'h05, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    // Timeout: 3 holds four cycles while 5 waits, then rotation with pulse.
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h28, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h28, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h28, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h28, 8'h20, 3'd5, 1'b1, 1'b1);
    add(8'h28, 8'h20, 3'd5, 1'b1, 1'b0);
    // 5 gone: 3 holds past the limit with no pulse.
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    // Single requester 4 drops: valid falls on the next cycle.
    add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);

    // Reset held with all requests asserted.
    rst_n = 1'b0;
    i_req = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", o_gnt, 8'h00);
    chk("rst_idx", {5'd0, o_gnt_idx}, 8'h00);
    chk("rst_vld", {7'd0, o_gnt_vld}, 8'h00);
    chk("rst_to",  {7'd0, o_timeout}, 8'h00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].req);
      chk($sformatf("vec%0d_gnt", i), o_gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_idx", i), {5'd0, o_gnt_idx}, {5'd0, vecs[i].idx});
      chk($sformatf("vec%0d_vld", i), {7'd0, o_gnt_vld}, {7'd0, vecs[i].vld});
      chk($sformatf("vec%0d_to", i),  {7'd0, o_timeout}, {7'd0, vecs[i].to});
    end

    // Mid-grant reset: grant must vanish before any clock edge, pointer back to 0.
    step(8'hFF);
    chk("mr_pre_gnt", o_gnt, 8'h20);
    step(8'hFF);
    chk("mr_hold_gnt", o_gnt, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_gnt", o_gnt, 8'h00);
    chk("mr_async_vld", {7'd0, o_gnt_vld}, 8'h00);
    chk("mr_async_idx", {5'd0, o_gnt_idx}, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF);
    chk("mr_post_gnt", o_gnt, 8'h01);
    chk("mr_post_idx", {5'd0, o_gnt_idx}, 8'h00);
    chk_model("mr_post");

    // Randomized traffic against the model.
    r = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0:       r = 8'($urandom);
        1:       r = 8'($urandom) & 8'($urandom);
        2:       r = 8'h00;
        default: r = r ^ (8'h01 << $urandom_range(0, 7));
      endcase
      step(r);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
